// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register / prefetch-queue slice.
// Holds the default instruction and opcode widths, the instruction word type
// and the opcode encoding shared by the decoder and verification code.
package ir_pkg;

  localparam int IR_WIDTH = 16;
  localparam int IR_OPW   = 4;

  typedef logic [IR_WIDTH-1:0] instr_t;

  // Opcode lives in the top IR_OPW bits of the instruction word.
  typedef enum logic [IR_OPW-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h5,
    OP_SUB   = 4'h6,
    OP_JUMP  = 4'hA,
    OP_BRZ   = 4'hB,
    OP_CALL  = 4'hC,
    OP_HALT  = 4'hF
  } opcode_t;

endpackage : ir_pkg

// File: rtl/ir_queue_mem.sv
// Purpose: DEPTH x WIDTH storage for the prefetch queue; sync write, async read.
// Latency: write visible on rdata the cycle after the edge; read is combinational.
// Backpressure: none here; the caller only asserts we when a slot is free.
// Ports: Clk clock; we/waddr/wdata write port; raddr/rdata read port.
// Storage is intentionally not reset: pointers and count define what is valid.
module ir_queue_mem
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : ir_queue_mem

// File: rtl/ir_queue.sv
// Purpose: instruction register fed by a DEPTH-entry prefetch FIFO, with flush.
// Latency: a word pushed in cycle N reaches outData on an Id at cycle >= N+1;
//          an Id on an empty queue with wrEn bypasses inData straight to outData.
// Backpressure: full is advisory; a push while full and not popping is dropped.
// Ports: Clk, Reset (sync, active-high); inData/wrEn fetch side; Id/Flush
//        from the control FSM; outData/opcode/outValid current instruction;
//        full/empty/count queue occupancy (excluding outData).
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH,
  parameter int DEPTH = 4,
  parameter int OPW   = IR_OPW
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           inData,
  input  logic                       wrEn,
  input  logic                       Id,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           outData,
  output logic [OPW-1:0]             opcode,
  output logic                       outValid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [WIDTH-1:0] head;
  logic             pop_eff;
  logic             bypass;
  logic             push_eff;
  logic             mem_we;

  // Flags come only from the registered count, never from this cycle's inputs.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign pop_eff  = Id && !empty;
  assign bypass   = Id && empty && wrEn;
  // A pop frees the head slot this same edge, so a full queue can still accept.
  assign push_eff = wrEn && (!full || pop_eff) && !bypass;
  // Reset and Flush discard anything arriving in the same cycle.
  assign mem_we   = push_eff && !Reset && !Flush;

  ir_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .Clk   (Clk),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (inData),
    .raddr (rptr),
    .rdata (head)
  );

  // Pointers and count.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) begin
        wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
      end
      if (pop_eff) begin
        rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Held instruction register. Flush invalidates but keeps the old word so
  // anything still looking at outData sees a stable value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      outData  <= '0;
      outValid <= 1'b0;
    end else if (Flush) begin
      outValid <= 1'b0;
    end else if (Id) begin
      if (pop_eff) begin
        outData  <= head;
        outValid <= 1'b1;
      end else if (wrEn) begin
        outData  <= inData;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

  assign opcode = outData[WIDTH-1 -: OPW];

endmodule : ir_queue

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (default WIDTH=16, DEPTH=4, OPW=4).
module tb_ir_queue;
  import ir_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] inData;
  logic        wrEn;
  logic        Id;
  logic        Flush;
  logic [15:0] outData;
  logic [3:0]  opcode;
  logic        outValid;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  ir_queue #(.WIDTH(16), .DEPTH(4), .OPW(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .inData   (inData),
    .wrEn     (wrEn),
    .Id       (Id),
    .Flush    (Flush),
    .outData  (outData),
    .opcode   (opcode),
    .outValid (outValid),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always #5 Clk = ~Clk;

  // Apply current inputs across one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; wrEn = 1'b0; Id = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1; inData = 16'h0;
    tick(); tick();
    Reset = 1'b0;
    total++; if (outData !== 16'h0000) begin bad++; $display("FAIL reset_outData got=%h want=0000", outData); end
    total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got=%b want=0", outValid); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
  endtask

  task automatic test_fifo_order();
    logic [15:0] words [3];
    logic [3:0]  ops   [3];
    words = '{16'hABCD, 16'h1234, 16'h5678};
    ops   = '{OP_JUMP, OP_LOAD, OP_ADD};
    idle();
    for (int i = 0; i < 3; i++) begin
      wrEn = 1'b1; inData = words[i];
      tick();
    end
    wrEn = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL order_count_filled got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      Id = 1'b1;
      tick();
      total++; if (outData !== words[i] || outValid !== 1'b1) begin bad++; $display("FAIL order_pop%0d got=%h/%b want=%h/1", i, outData, outValid, words[i]); end
      total++; if (opcode !== ops[i]) begin bad++; $display("FAIL order_opcode%0d got=%h want=%h", i, opcode, ops[i]); end
      total++; if (count !== 3'(2 - i)) begin bad++; $display("FAIL order_count%0d got=%0d want=%0d", i, count, 2 - i); end
    end
    Id = 1'b0;
  endtask

  task automatic test_full_drop();
    idle();
    for (int i = 1; i <= 5; i++) begin
      wrEn = 1'b1; inData = 16'(i);
      tick();
      if (i >= 4) begin
        total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL full_after_push%0d got full=%b count=%0d want 1/4", i, full, count); end
      end
    end
    wrEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      Id = 1'b1;
      tick();
      total++; if (outData !== 16'(i)) begin bad++; $display("FAIL drain%0d got=%h want=%h", i, outData, 16'(i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
    tick();
    total++; if (outValid !== 1'b0 || outData !== 16'h0004) begin bad++; $display("FAIL id_on_empty got=%h/%b want=0004/0", outData, outValid); end
    Id = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] expect_q [4];
    expect_q = '{16'h0012, 16'h0013, 16'h0014, 16'h00AA};
    idle();
    for (int i = 0; i < 4; i++) begin
      wrEn = 1'b1; inData = 16'h0011 + 16'(i);
      tick();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL pp_full got=%b want=1", full); end
    wrEn = 1'b1; Id = 1'b1; inData = 16'h00AA;
    tick();
    total++; if (outData !== 16'h0011 || count !== 3'd4) begin bad++; $display("FAIL pp_same_cycle got=%h count=%0d want=0011/4", outData, count); end
    wrEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (outData !== expect_q[i]) begin bad++; $display("FAIL pp_drain%0d got=%h want=%h", i, outData, expect_q[i]); end
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL pp_final_count got=%0d want=0", count); end
    Id = 1'b0;
  endtask

  task automatic test_bypass();
    idle();
    wrEn = 1'b1; Id = 1'b1; inData = 16'hBEEF;
    tick();
    idle();
    total++; if (outData !== 16'hBEEF || outValid !== 1'b1) begin bad++; $display("FAIL bypass_out got=%h/%b want=BEEF/1", outData, outValid); end
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL bypass_queue got count=%0d empty=%b want 0/1", count, empty); end
    total++; if (opcode !== OP_BRZ) begin bad++; $display("FAIL bypass_opcode got=%h want=B", opcode); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 1; i <= 3; i++) begin
      wrEn = 1'b1; inData = 16'h0101 * 16'(i);
      tick();
    end
    Flush = 1'b1; wrEn = 1'b1; Id = 1'b1; inData = 16'hFFFF;
    tick();
    idle();
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL flush_count got=%0d empty=%b want 0/1", count, empty); end
    total++; if (outValid !== 1'b0 || outData !== 16'hBEEF) begin bad++; $display("FAIL flush_out got=%h/%b want=BEEF/0", outData, outValid); end
    wrEn = 1'b1; inData = 16'hC0DE;
    tick();
    wrEn = 1'b0; Id = 1'b1;
    tick();
    Id = 1'b0;
    total++; if (outData !== 16'hC0DE || outValid !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL flush_next got=%h/%b count=%0d want=C0DE/1/0", outData, outValid, count); end
  endtask

  task automatic test_reset_midstream();
    idle();
    for (int i = 0; i < 2; i++) begin
      wrEn = 1'b1; inData = 16'h7700 + 16'(i);
      tick();
    end
    Reset = 1'b1; wrEn = 1'b1; Id = 1'b1; Flush = 1'b0; inData = 16'h9999;
    tick();
    idle();
    total++; if (outData !== 16'h0000 || outValid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL midreset got=%h/%b count=%0d want=0000/0/0", outData, outValid, count); end
    Id = 1'b1;
    tick();
    Id = 1'b0;
    total++; if (outValid !== 1'b0 || outData !== 16'h0000) begin bad++; $display("FAIL midreset_no_survivor got=%h/%b want=0000/0", outData, outValid); end
  endtask

  initial begin
    inData = '0;
    idle();
    test_reset();
    test_fifo_order();
    test_full_drop();
    test_full_push_pop();
    test_bypass();
    test_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ir_queue
